// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of
// the IF/ID register. Owns the fetch PC, issues one word request at a time to
// instruction memory, parks a response in a one-entry hold buffer when the
// downstream slot is stalled, and kills wrong-path fetches on redirect.
//
// Ports:
//   clk, rst_n            clock (posedge) and asynchronous active-low reset
//   stall_i               downstream cannot accept the presented instruction
//   redirect_i            taken branch/jump from EX (one-cycle pulse)
//   redirect_pc_i[31:0]   redirect target, low two bits ignored
//   imem_req_o            combinational fetch request
//   imem_addr_o[31:0]     combinational request word address
//   imem_rvalid_i         in-order response valid
//   imem_rdata_i[31:0]    instruction word
//   pc_if_o[31:0]         PC of the presented instruction
//   instr_if_o[31:0]      presented instruction (NOP_INSTR while not valid)
//   valid_if_o            output slot holds a real instruction
//
// Optional feature macro IF_PERF_CNT_EN:
//   adds fetch_cnt_o[31:0] (slot loads) and stall_cnt_o[31:0] (cycles with a
//   valid but stalled slot). Both wrap at 2^32.
// ============================================================================
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_if_o,
   output logic [31:0] instr_if_o,
   output logic        valid_if_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;

   logic        slot_free;
   logic        load_slot;
   logic [31:0] load_pc;
   logic [31:0] load_instr;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_tgt;

   assign slot_free    = !valid_q || !stall_i;
   assign pc_plus4     = fetch_pc_q + 32'd4;
   assign redirect_tgt = redirect_pc_i & ~32'd3;

   // State register plus the fetch PC and hold buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_PC;
         hold_pc_q    <= 32'd0;
         hold_instr_q <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   // Fetch control. A redirect always wins over a response in the same cycle:
   // that response belongs to the wrong path. In WAIT a response can be
   // forwarded straight into a free slot while the next request goes out in
   // the same cycle, which is what sustains one instruction per cycle.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      hold_pc_d    = hold_pc_q;
      hold_instr_d = hold_instr_q;
      imem_req_o   = 1'b0;
      imem_addr_o  = fetch_pc_q;
      load_slot    = 1'b0;
      load_pc      = fetch_pc_q;
      load_instr   = imem_rdata_i;

      case (state_q)
         IDLE: begin
            if (redirect_i) begin
               fetch_pc_d = redirect_tgt;
            end else begin
               imem_req_o = 1'b1;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (redirect_i) begin
               fetch_pc_d = redirect_tgt;
               state_d    = imem_rvalid_i ? IDLE : DROP;
            end else if (imem_rvalid_i && slot_free) begin
               load_slot   = 1'b1;
               fetch_pc_d  = pc_plus4;
               imem_req_o  = 1'b1;
               imem_addr_o = pc_plus4;
            end else if (imem_rvalid_i) begin
               hold_pc_d    = fetch_pc_q;
               hold_instr_d = imem_rdata_i;
               fetch_pc_d   = pc_plus4;
               state_d      = HOLD;
            end
         end
         HOLD: begin
            if (redirect_i) begin
               fetch_pc_d = redirect_tgt;
               state_d    = IDLE;
            end else if (slot_free) begin
               load_slot  = 1'b1;
               load_pc    = hold_pc_q;
               load_instr = hold_instr_q;
               state_d    = IDLE;
            end
         end
         DROP: begin
            if (redirect_i) begin
               fetch_pc_d = redirect_tgt;
            end
            if (imem_rvalid_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output slot: kill on redirect, else load, else drain on consumption,
   // else hold while stalled.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (redirect_i) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (load_slot) begin
         pc_d    = load_pc;
         instr_d = load_instr;
         valid_d = 1'b1;
      end else if (valid_q && !stall_i) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end
   end

   // Output slot registers feeding the IF/ID register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= 32'd0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc_if_o    = pc_q;
   assign instr_if_o = instr_q;
   assign valid_if_o = valid_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   // Performance counters; both wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         if (load_slot) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (valid_q && stall_i) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
